dbuf_page_reader: RTL
=====================

// Module: dbuf_page_reader
// PURPOSE
//  Drains one filled half of the hit-buffer readout double buffer.
//  Waits for rd_busy, then reads dpram_len words through the double buffer read port.
//  Emits the words as a valid/ready stream with tlast on the final word.
//  Pulses done so the double buffer frees the half and swaps its read index.
//  Downstream neighbour of double_buffer; runs on that block's clock (rd_clk == clk).
// PARAMETERS
//  P_RD_ADDR_WIDTH  9   read-port word address width (page depth = 2**W words)
//  P_RD_DATA_WIDTH  64  read-port / stream data width
//  P_RD_LATENCY     1   DPRAM rd_addr->rd_dout latency in cycles (1 or 2)
//  P_FIFO_DEPTH     4   output skid FIFO depth; must be >= P_RD_LATENCY+2, power of 2
//  P_SETTLE_CYCLES  3   wait after done before rd_busy is sampled again
// PORTS
//  clk           in   1   clock (same as double buffer clk/rd_clk)
//  rst           in   1   synchronous, active-high reset
//  rd_busy       in   1   current read half holds a page
//  dpram_len     in   16  words in current page (units of P_RD_DATA_WIDTH)
//  rd_addr       out  W   DPRAM read address
//  rd_dout       in   D   DPRAM read data, P_RD_LATENCY after rd_addr
//  done          out  1   one-cycle pulse: page fully consumed
//  m_tdata       out  D   stream data
//  m_tvalid      out  1   stream valid
//  m_tlast       out  1   last word of page
//  m_tready      in   1   stream ready
//  active        out  1   high from page accept until done pulse, inclusive
//  len_err       out  1   sticky: a dpram_len > 2**W was seen; cleared only by rst
//  pages_out     out  16  count of completed pages; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0. FSM enters S_IDLE. FIFO and in-flight count are emptied.
//  A reset in mid-page abandons the page; no done is issued.
//  Transfer: a word moves when m_tvalid && m_tready. m_tdata/m_tlast are stable while valid && !ready.
//  FSM:
//   S_IDLE   : if rd_busy, latch len = dpram_len and go to S_LOAD.
//   S_LOAD   : if len > 2**W, clamp len to 2**W and set len_err.
//              If len == 0, go to S_DONE (no stream words). Else set addr = 0, go to S_READ.
//   S_READ   : issue rd_addr = addr when fifo_count + inflight < P_FIFO_DEPTH.
//              Each issue decrements remaining count. After the last issue, go to S_DRAIN.
//   S_DRAIN  : go to S_DONE when inflight == 0 and the FIFO is empty after the last handshake.
//   S_DONE   : done = 1 for exactly 1 cycle; pages_out++; go to S_SETTLE.
//   S_SETTLE : count P_SETTLE_CYCLES, then go to S_IDLE. rd_busy is ignored here.
//              The double buffer needs 2 cycles to clear busy and swap rd index.
//  Read pipeline: shift register of P_RD_LATENCY valid bits carrying a last-tag.
//   On its output, rd_dout and the tag are pushed into the FIFO.
//   The credit rule guarantees the FIFO never overflows.
//  Throughput: with m_tready held high, 1 word per clk.
//   First m_tvalid appears P_RD_LATENCY+2 clks after rd_busy is sampled high in S_IDLE.
//  Page turnaround: done -> next S_IDLE = P_SETTLE_CYCLES+1 clks.
//  rd_addr holds its last value when not issuing. Address math is W bits.
//   Full-depth page (len = 2**W) covers addr 0..2**W-1 with no wrap.
//  Simultaneous events: a FIFO push and pop in the same cycle keep the count unchanged.
//   Credit uses the post-pop count.
//  rd_busy dropping mid-page is not a legal input; the block ignores it and completes the page.
// STRUCTURE
//  Shared package dbuf_pkg: FSM state localparams (S_IDLE..S_SETTLE), DPRAM latency constant.
//  The double buffer and this block share these.
//  Sub-module page_rdout_fifo: synchronous FWFT FIFO, width D+1 (data+last), depth P_FIFO_DEPTH.
//   Outputs count; no overflow logic needed.
//  FSM, credit counter, latency shift register and pages_out counter live in this top level.
// TESTING
//  1. len=8, m_tready=1 -> 8 back-to-back words, data = addr 0..7, tlast on word 8, one done, pages_out=1.
//  2. len=16, m_tready toggles 1/0 each cycle -> no word lost or duplicated.
//     Data held during stall. FIFO count never > P_FIFO_DEPTH.
//  3. len=0 -> no m_tvalid, done pulse 2 clks after rd_busy seen, pages_out increments.
//  4. len=600 with W=9 -> exactly 512 words, tlast on addr 511, len_err=1 and stays 1 across later pages.
//  5. Two pages in a row through a real double_buffer, lens 4 and 5.
//     Words from half 0 then half 1, two done pulses ≥ P_SETTLE_CYCLES+1 apart, no double-read of half 0.
//  6. rst asserted mid-page (after word 3 of 10) -> all outputs 0 next clk, no done.
//     After release with rd_busy=1, a new page starts from addr 0.

Source files
------------

// File: rtl/dbuf_pkg.sv
// Shared definitions for the hit-buffer readout double buffer and its page reader.
package dbuf_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_SETTLE = 3'd5
  } dbuf_state_e;

  // DPRAM rd_addr -> rd_dout latency used by both sides of the double buffer.
  localparam int DBUF_RD_LATENCY = 1;

endpackage

// File: rtl/page_rdout_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, data} between the DPRAM
// read pipeline and the output stream. Overflow is prevented by the reader's credit rule.
module page_rdout_fifo #(
  parameter int P_WIDTH = 65,
  parameter int P_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       rd_en,
  output logic [P_WIDTH-1:0]         rd_data,
  output logic [$clog2(P_DEPTH):0]   count
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Head is forced to zero when empty so the stream outputs read 0 after reset.
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dbuf_page_reader.sv
// Drains one filled half of the readout double buffer into a valid/ready stream,
// tagging the final word with tlast and pulsing done so the half can be freed.
module dbuf_page_reader
  import dbuf_pkg::*;
#(
  parameter int P_RD_ADDR_WIDTH = 9,
  parameter int P_RD_DATA_WIDTH = 64,
  parameter int P_RD_LATENCY    = DBUF_RD_LATENCY,
  parameter int P_FIFO_DEPTH    = 4,
  parameter int P_SETTLE_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_busy,
  input  logic [15:0]                dpram_len,
  output logic [P_RD_ADDR_WIDTH-1:0] rd_addr,
  input  logic [P_RD_DATA_WIDTH-1:0] rd_dout,
  output logic                       done,
  output logic [P_RD_DATA_WIDTH-1:0] m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic                       active,
  output logic                       len_err,
  output logic [15:0]                pages_out,
  output dbuf_state_e                dbg_state
);

  localparam int W  = P_RD_ADDR_WIDTH;
  localparam int D  = P_RD_DATA_WIDTH;
  localparam int L  = P_RD_LATENCY;
  localparam int CW = $clog2(P_FIFO_DEPTH) + 1;
  localparam int SW = $clog2(P_SETTLE_CYCLES + 1);
  localparam logic [16:0] PAGE_WORDS = 17'(2 ** W);
  localparam logic [CW:0] DEPTH_V    = (CW + 1)'(P_FIFO_DEPTH);

  dbuf_state_e   state;
  logic [16:0]   remaining;
  logic [SW-1:0] settle_cnt;
  logic [L-1:0]  pipe_v;
  logic [L-1:0]  pipe_last;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] post_pop;
  logic [CW:0]   credit_used;
  logic [D:0]    fifo_out;
  logic          push;
  logic          pop;
  logic          issue;
  logic          issue_last;

  // Stream handshake: a word moves when m_tvalid && m_tready; while m_tvalid && !m_tready
  // the FIFO head (m_tdata, m_tlast) is held unchanged.
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = (fifo_count != '0);
  assign m_tdata  = fifo_out[D-1:0];
  assign m_tlast  = fifo_out[D];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // Credit counts the FIFO after this cycle's pop plus reads still in the DPRAM pipe.
  assign post_pop    = fifo_count - CW'(pop);
  assign credit_used = {1'b0, post_pop} + {1'b0, inflight};
  assign issue       = (state == S_READ) && (credit_used < DEPTH_V);
  assign issue_last  = (remaining == 17'd1);
  assign push        = pipe_v[L-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      pipe_v    <= L'({pipe_v, issue});
      pipe_last <= L'({pipe_last, issue & issue_last});
    end
  end

  page_rdout_fifo #(
    .P_WIDTH (D + 1),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({pipe_last[L-1], rd_dout}),
    .rd_en   (pop),
    .rd_data (fifo_out),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      settle_cnt <= '0;
      rd_addr    <= '0;
      done       <= 1'b0;
      active     <= 1'b0;
      len_err    <= 1'b0;
      pages_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_busy) begin
            remaining <= {1'b0, dpram_len};
            active    <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (remaining > PAGE_WORDS) begin
            remaining <= PAGE_WORDS;
            len_err   <= 1'b1;
          end
          if (remaining == '0) begin
            state <= S_DONE;
          end else begin
            rd_addr <= '0;
            state   <= S_READ;
          end
        end
        S_READ: begin
          // The last issued address is kept on rd_addr, so a full page never wraps.
          if (issue) begin
            remaining <= remaining - 17'd1;
            if (issue_last) state <= S_DRAIN;
            else            rd_addr <= rd_addr + W'(1);
          end
        end
        S_DRAIN: begin
          if (inflight == '0 && post_pop == '0) state <= S_DONE;
        end
        S_DONE: begin
          done       <= 1'b1;
          pages_out  <= pages_out + 16'd1;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          // The double buffer clears busy and swaps its read half during this window.
          active <= 1'b0;
          if (settle_cnt == SW'(P_SETTLE_CYCLES)) state <= S_IDLE;
          else                                    settle_cnt <= settle_cnt + SW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
